// File: rtl/ivl_uvm_ovl_fifo_index_pkg.sv
// Shared types for the multi-channel FIFO index checker.
//   err_code_e : encoding of the sticky first-error kind
//   MSG_PREFIX : common tag for checker messages
package ivl_uvm_ovl_fifo_index_pkg;
  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_OVERFLOW  = 2'd2,
    ERR_SIMUL     = 2'd3
  } err_code_e;

  localparam string MSG_PREFIX = "[OVL fifo_index]";
endpackage

// File: rtl/ivl_uvm_ovl_fifo_index_chan.sv
// One FIFO occupancy channel: counter, underflow/overflow/simul checks,
// registered fire bits.
//   clock, reset (async high), enable : control
//   push, pop                         : entries pushed/popped this cycle
//   count                             : current occupancy
//   fire_*_d                          : fire bits about to be registered (for arbitration)
//   fire_*                            : registered fire bits
module ivl_uvm_ovl_fifo_index_chan
  import ivl_uvm_ovl_fifo_index_pkg::*;
#(
  parameter int DEPTH                 = 4,
  parameter int PUSH_WIDTH            = 1,
  parameter int POP_WIDTH             = 1,
  parameter int SIMULTANEOUS_PUSH_POP = 1,
  parameter int CNT_W                 = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PUSH_WIDTH-1:0] push,
  input  logic [POP_WIDTH-1:0]  pop,
  output logic [CNT_W-1:0]      count,
  output logic                  fire_underflow_d,
  output logic                  fire_overflow_d,
  output logic                  fire_simul_d,
  output logic                  fire_underflow,
  output logic                  fire_overflow,
  output logic                  fire_simul
);
  // Wide enough that n + p - q never wraps when no underflow occurs.
  localparam int AW = CNT_W + ((PUSH_WIDTH > POP_WIDTH) ? PUSH_WIDTH : POP_WIDTH) + 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic             fire_underflow_q, fire_overflow_q, fire_simul_q;
  logic [AW-1:0]    n_a, p_a, q_a, net_a;

  always_comb begin
    n_a              = AW'(count_q);
    p_a              = AW'(push);
    q_a              = AW'(pop);
    // Only meaningful when q <= n; on underflow this value is ignored.
    net_a            = n_a + p_a - q_a;
    count_d          = count_q;
    fire_underflow_d = 1'b0;
    fire_overflow_d  = 1'b0;
    fire_simul_d     = 1'b0;
    if (enable) begin
      fire_underflow_d = (q_a > n_a);
      fire_overflow_d  = !fire_underflow_d && (net_a > DEPTH_A);
      fire_simul_d     = (SIMULTANEOUS_PUSH_POP == 0) && (push != '0) && (pop != '0);
      // Pop is applied first, so an underflow drains to empty before the push lands.
      if (fire_underflow_d)     count_d = (p_a > DEPTH_A) ? CNT_W'(DEPTH) : CNT_W'(p_a);
      else if (fire_overflow_d) count_d = CNT_W'(DEPTH);
      else                      count_d = CNT_W'(net_a);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q          <= '0;
      fire_underflow_q <= 1'b0;
      fire_overflow_q  <= 1'b0;
      fire_simul_q     <= 1'b0;
    end else begin
      count_q          <= count_d;
      fire_underflow_q <= fire_underflow_d;
      fire_overflow_q  <= fire_overflow_d;
      fire_simul_q     <= fire_simul_d;
    end
  end

  assign count          = count_q;
  assign fire_underflow = fire_underflow_q;
  assign fire_overflow  = fire_overflow_q;
  assign fire_simul     = fire_simul_q;
endmodule

// File: rtl/ivl_uvm_ovl_fifo_index_mc.sv
// Multi-channel FIFO index checker: CHANNELS independent occupancy trackers
// plus a sticky record of the first error seen since reset.
//   clock, reset (async high), enable
//   push/pop       : packed per-channel counts, channel c at [c*W +: W]
//   count          : packed per-channel occupancy
//   fire_*         : per-channel registered fire bits
//   error_sticky   : any fire since reset
//   first_err_ch/_code : channel and kind of the first error
module ivl_uvm_ovl_fifo_index_mc
  import ivl_uvm_ovl_fifo_index_pkg::*;
#(
  parameter int  DEPTH                 = 4,
  parameter int  CHANNELS              = 2,
  parameter int  PUSH_WIDTH            = 1,
  parameter int  POP_WIDTH             = 1,
  parameter int  SIMULTANEOUS_PUSH_POP = 1,
  localparam int CNT_W                 = $clog2(DEPTH + 1),
  localparam int CH_W                  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [CHANNELS*PUSH_WIDTH-1:0] push,
  input  logic [CHANNELS*POP_WIDTH-1:0]  pop,
  output logic [CHANNELS*CNT_W-1:0]      count,
  output logic [CHANNELS-1:0]            fire_underflow,
  output logic [CHANNELS-1:0]            fire_overflow,
  output logic [CHANNELS-1:0]            fire_simul,
  output logic                           error_sticky,
  output logic [CH_W-1:0]                first_err_ch,
  output logic [1:0]                     first_err_code
);
  logic [CHANNELS-1:0] unf_d, ovf_d, sim_d;
  logic                error_sticky_q, error_sticky_d;
  logic [CH_W-1:0]     first_err_ch_q, first_err_ch_d;
  err_code_e           first_err_code_q, first_err_code_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    ivl_uvm_ovl_fifo_index_chan #(
      .DEPTH                 (DEPTH),
      .PUSH_WIDTH            (PUSH_WIDTH),
      .POP_WIDTH             (POP_WIDTH),
      .SIMULTANEOUS_PUSH_POP (SIMULTANEOUS_PUSH_POP),
      .CNT_W                 (CNT_W)
    ) u_chan (
      .clock            (clock),
      .reset            (reset),
      .enable           (enable),
      .push             (push[g*PUSH_WIDTH +: PUSH_WIDTH]),
      .pop              (pop[g*POP_WIDTH +: POP_WIDTH]),
      .count            (count[g*CNT_W +: CNT_W]),
      .fire_underflow_d (unf_d[g]),
      .fire_overflow_d  (ovf_d[g]),
      .fire_simul_d     (sim_d[g]),
      .fire_underflow   (fire_underflow[g]),
      .fire_overflow    (fire_overflow[g]),
      .fire_simul       (fire_simul[g])
    );
  end

  // Arbitrate on the pre-register fires so the record becomes visible in
  // the same cycle as the first fire_* high. Scanning downward lets the
  // lowest firing channel win.
  always_comb begin
    error_sticky_d   = error_sticky_q;
    first_err_ch_d   = first_err_ch_q;
    first_err_code_d = first_err_code_q;
    if (!error_sticky_q && ((|unf_d) || (|ovf_d) || (|sim_d))) begin
      error_sticky_d = 1'b1;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (unf_d[c] || ovf_d[c] || sim_d[c]) begin
          first_err_ch_d   = CH_W'(c);
          first_err_code_d = unf_d[c] ? ERR_UNDERFLOW :
                             ovf_d[c] ? ERR_OVERFLOW  : ERR_SIMUL;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_sticky_q   <= 1'b0;
      first_err_ch_q   <= '0;
      first_err_code_q <= ERR_NONE;
    end else begin
      error_sticky_q   <= error_sticky_d;
      first_err_ch_q   <= first_err_ch_d;
      first_err_code_q <= first_err_code_d;
    end
  end

  assign error_sticky   = error_sticky_q;
  assign first_err_ch   = first_err_ch_q;
  assign first_err_code = first_err_code_q;
endmodule
